fft_sample_buffer: RTL
======================

// Module: fft_sample_buffer
// PURPOSE
//  Parametrised sample store for the FFT datapath: loads a frame of complex samples over a valid/ready
//  input stream, lends the store to the butterfly engine for in-place computation, then drains results
//  over a valid/ready output stream. Successor to the fixed 12-bit RAM + cache pairing, with runtime frame length.
// PARAMETERS
//  DATA_W      16  bits per real/imag part; sample word SW = 2*DATA_W ({re,im}, re in MSBs)
//  LOG2_N_MAX  12  log2 of max frame length; store depth 2**LOG2_N_MAX; address width AW = LOG2_N_MAX
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        begin a frame (sampled only in IDLE)
//  cfg_log2n    in   4        frame length log2; captured on accepted start
//  busy         out  1        high in any state except IDLE
//  cfg_err      out  1        1-cycle pulse: start rejected (cfg_log2n==0 or >LOG2_N_MAX)
//  in_data      in   SW       input sample
//  in_valid     in   1        input sample valid
//  in_ready     out  1        buffer accepts input (LOAD only)
//  eng_start    out  1        1-cycle pulse: frame loaded, engine may run
//  eng_done     in   1        engine finished; ends COMPUTE
//  eng_rd_addr  in   AW       engine read address
//  eng_rd_data  out  SW       store data at eng_rd_addr of previous cycle
//  eng_wr_en    in   1        engine write strobe (honoured in COMPUTE only)
//  eng_wr_addr  in   AW       engine write address
//  eng_wr_data  in   SW       engine write data
//  out_data     out  SW       output sample
//  out_valid    out  1        output sample valid
//  out_ready    in   1        downstream accepts
//  out_last     out  1        qualifies final sample of frame
//  done         out  1        1-cycle pulse on last output transfer
// BEHAVIOUR
//  - Reset: state IDLE; all counters 0; every output 0 (in_ready, out_valid, pulses, busy included).
//  - FSM IDLE->LOAD on start with valid cfg (N=2**cfg_log2n latched); invalid cfg: stay IDLE, pulse cfg_err.
//  - LOAD: in_ready=1; each in_valid&in_ready writes store[waddr(cnt)], cnt++. On cnt==N-1 transfer: ->COMPUTE,
//    eng_start pulses the following cycle (first COMPUTE cycle). in_ready drops the cycle after last transfer.
//  - COMPUTE: store port A = engine write, port B = engine read, 1-cycle read latency, read-before-write
//    on same address same cycle (old data returned). eng_done -> DRAIN next cycle. eng_* ignored outside COMPUTE.
//  - DRAIN: linear read addresses 0..N-1; 2-entry output skid so sustained 1 sample/cycle when out_ready=1.
//    First out_valid no earlier than 2 cycles after DRAIN entry. out_data/out_valid/out_last stable while
//    out_valid&!out_ready. out_last with address N-1; on its transfer done pulses, ->IDLE next cycle.
//  - Counters AW+1 bits; never wrap past N-1; addresses >=N never touched in LOAD/DRAIN.
//  - start while busy: ignored. cfg_log2n changes after capture: no effect on current frame.
//  - rst_n low mid-frame: immediate return to IDLE, outputs to reset values; store contents undefined.
// CONFIGURATION
//  - FFT_BUF_BITREV_EN defined: LOAD writes to bit-reversed address, reversal over low cfg_log2n bits only
//    (N=8: sample 1 -> addr 4, sample 3 -> addr 6); DRAIN stays linear (natural-order output for DIT engine).
//  - Not defined: LOAD writes linear address = cnt; engine is responsible for ordering.
// STRUCTURE
//  - fft_pkg: state enum (IDLE, LOAD, COMPUTE, DRAIN), bitrev(addr, log2n) function, SW/AW helpers.
//  - Sub-module fft_sample_ram: simple dual-port, 1 write port, 1 registered read port, depth 2**AW,
//    read-before-write. Port muxing by state lives in fft_sample_buffer.
// TESTING
//  - Reset: assert rst_n=0 mid-LOAD -> busy=0, in_ready=0, out_valid=0 same cycle; next start accepted.
//  - Bad cfg: start with cfg_log2n=0 and =13 (LOG2_N_MAX=12) -> cfg_err 1-cycle pulse each, busy stays 0.
//  - Passthrough N=8, samples 0..7, eng_done 1 cycle after eng_start, out_ready=1 -> outputs 0..7 linear
//    (no BITREV) / 0,4,2,6,1,5,3,7 (BITREV); out_last on 8th, done pulse, back-to-back beats.
//  - Backpressure N=16: out_ready toggled random 50% -> no loss/duplication, data held while stalled.
//  - Engine access: write 0xA5A5_5A5A to addr 3 in COMPUTE, read addr 3 next cycle -> new value after
//    1-cycle latency; same-cycle read/write -> old value.
//  - Max frame N=4096 with gaps on in_valid -> exactly 4096 inputs accepted, in_ready low afterwards.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT sample buffer
package fft_pkg;

    // Buffer lifecycle: fill, lend to engine, drain results.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // Width of the bit-reversal helper; must cover the largest address width in use.
    localparam int BITREV_W = 16;

    // Sample word is {re, im}, so twice the per-part width.
    function automatic int sample_width(input int data_w);
        return 2 * data_w;
    endfunction

    // Store address width equals log2 of the maximum frame length.
    function automatic int addr_width(input int log2_n_max);
        return log2_n_max;
    endfunction

    // Reverse only the low log2n bits of addr; higher bits come back as zero.
    function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] addr,
                                                   input logic [3:0]          log2n);
        logic [BITREV_W-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_W; i++) begin
            if (i < int'(log2n)) begin
                r[log2n - 4'd1 - 4'(i)] = addr[4'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// rtl/fft_sample_ram.sv - simple dual-port sample store, registered read, read-before-write
module fft_sample_ram #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rd_data;

    // Write port; contents are left uninitialised and survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port samples the array before this edge's write lands, so a same-address
    // collision returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_sample_buffer.sv
// rtl/fft_sample_buffer.sv - frame store for the FFT datapath (optional bit-reversed load: FFT_BUF_BITREV_EN)
module fft_sample_buffer
    import fft_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOG2_N_MAX = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3:0]              cfg_log2n,
    output logic                    busy,
    output logic                    cfg_err,
    input  logic [2*DATA_W-1:0]     in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    eng_start,
    input  logic                    eng_done,
    input  logic [LOG2_N_MAX-1:0]   eng_rd_addr,
    output logic [2*DATA_W-1:0]     eng_rd_data,
    input  logic                    eng_wr_en,
    input  logic [LOG2_N_MAX-1:0]   eng_wr_addr,
    input  logic [2*DATA_W-1:0]     eng_wr_data,
    output logic [2*DATA_W-1:0]     out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    done
);

    localparam int SW = sample_width(DATA_W);
    localparam int AW = addr_width(LOG2_N_MAX);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_log2n;
    logic [AW:0]         r_cnt;
    logic                r_issue_all;
    logic                r_rd_pend;
    logic                r_rd_pend_last;
    logic                r_eng_start;
    logic                r_cfg_err;

    logic [1:0][SW-1:0]  r_fifo_data;
    logic [1:0]          r_fifo_last;
    logic                r_head;
    logic                r_tail;
    logic [1:0]          r_fifo_cnt;

    logic                w_cfg_bad;
    logic                w_start_ok;
    logic [AW:0]         w_last_idx;
    logic                w_in_fire;
    logic                w_load_last;
    logic                w_pop;
    logic [2:0]          w_slots_used;
    logic                w_issue;
    logic                w_issue_last;
    logic [AW-1:0]       w_waddr;

    logic                w_ram_wr_en;
    logic [AW-1:0]       w_ram_wr_addr;
    logic [SW-1:0]       w_ram_wr_data;
    logic                w_ram_rd_en;
    logic [AW-1:0]       w_ram_rd_addr;
    logic [SW-1:0]       w_ram_rd_data;

    assign w_cfg_bad   = (cfg_log2n == 4'd0) || (int'(cfg_log2n) > LOG2_N_MAX);
    assign w_start_ok  = (r_state == ST_IDLE) && start && !w_cfg_bad;
    assign w_last_idx  = ({{AW{1'b0}}, 1'b1} << r_log2n) - {{AW{1'b0}}, 1'b1};
    assign w_in_fire   = (r_state == ST_LOAD) && in_valid;
    assign w_load_last = w_in_fire && (r_cnt == w_last_idx);

    // Drain read-ahead: a read may be issued only if the data already buffered plus the
    // read in flight, minus what leaves this cycle, still fits in the two skid slots.
    assign w_pop        = out_valid && out_ready;
    assign w_slots_used = {1'b0, r_fifo_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_issue      = (r_state == ST_DRAIN) && !r_issue_all && (w_slots_used < 3'd2);
    assign w_issue_last = w_issue && (r_cnt == w_last_idx);

`ifdef FFT_BUF_BITREV_EN
    logic [BITREV_W-1:0] w_rev;
    logic                w_unused_rev_hi;
    assign w_rev           = bitrev(BITREV_W'(r_cnt), r_log2n);
    assign w_waddr         = w_rev[AW-1:0];
    assign w_unused_rev_hi = ^w_rev[BITREV_W-1:AW];
`else
    assign w_waddr = r_cnt[AW-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        in_ready    = (r_state == ST_LOAD);
        done        = w_pop && out_last;
        case (r_state)
            ST_IDLE:    if (w_start_ok)  w_state_nxt = ST_LOAD;
            ST_LOAD:    if (w_load_last) w_state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (eng_done)    w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (done)        w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame config capture, load/drain address counter and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_log2n        <= 4'd0;
            r_cnt          <= '0;
            r_issue_all    <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            r_eng_start    <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_eng_start    <= w_load_last;
            r_cfg_err      <= (r_state == ST_IDLE) && start && w_cfg_bad;
            r_rd_pend      <= w_issue;
            r_rd_pend_last <= w_issue_last;
            if (w_start_ok) begin
                r_log2n     <= cfg_log2n;
                r_cnt       <= '0;
                r_issue_all <= 1'b0;
            end
            if (w_in_fire) begin
                r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;
            end
            // Counter parks at N-1 on the final read instead of stepping past the frame.
            if (w_issue) begin
                if (w_issue_last) begin
                    r_issue_all <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Two-entry skid buffer between the registered store read and the output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data <= '0;
            r_fifo_last <= '0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (r_rd_pend) begin
                r_fifo_data[r_tail] <= w_ram_rd_data;
                r_fifo_last[r_tail] <= r_rd_pend_last;
                r_tail              <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

    // Store port ownership follows the state: loader or engine writes, engine or drain reads.
    always_comb begin
        w_ram_wr_en   = 1'b0;
        w_ram_wr_addr = eng_wr_addr;
        w_ram_wr_data = eng_wr_data;
        w_ram_rd_en   = 1'b0;
        w_ram_rd_addr = r_cnt[AW-1:0];
        case (r_state)
            ST_LOAD: begin
                w_ram_wr_en   = w_in_fire;
                w_ram_wr_addr = w_waddr;
                w_ram_wr_data = in_data;
            end
            ST_COMPUTE: begin
                w_ram_wr_en   = eng_wr_en;
                w_ram_rd_en   = 1'b1;
                w_ram_rd_addr = eng_rd_addr;
            end
            ST_DRAIN: begin
                w_ram_rd_en   = w_issue;
            end
            default: ;
        endcase
    end

    fft_sample_ram #(
        .DW (SW),
        .AW (AW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_ram_wr_en),
        .i_wr_addr (w_ram_wr_addr),
        .i_wr_data (w_ram_wr_data),
        .i_rd_en   (w_ram_rd_en),
        .i_rd_addr (w_ram_rd_addr),
        .o_rd_data (w_ram_rd_data)
    );

    assign eng_rd_data = w_ram_rd_data;
    assign eng_start   = r_eng_start;
    assign cfg_err     = r_cfg_err;
    assign out_valid   = (r_fifo_cnt != 2'd0);
    assign out_data    = r_fifo_data[r_head];
    assign out_last    = out_valid && r_fifo_last[r_head];

endmodule
